// File: rtl/axis_depacketizer.sv
// rtl/axis_depacketizer.sv - fixed-length AXI-Stream packet checker with indexed, registered output
// Forwards beats of well-framed packets and resynchronises on tlast after a length error.
module axis_depacketizer #(
  parameter int DATA_W  = 32,
  parameter int USER_W  = 8,
  parameter int PKT_LEN = 256,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = $clog2(PKT_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [USER_W-1:0] s_tuser,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  output logic [DATA_W-1:0] m_tdata,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_sop,
  output logic              m_eop,
  output logic [IDX_W-1:0]  m_idx,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  short_err_cnt,
  output logic [CNT_W-1:0]  long_err_cnt,
  output logic              err_pulse,
  output logic              aligned
);

  typedef enum logic {ALIGNED = 1'b0, HUNT = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
  logic [USER_W-1:0]   m_tuser_q, m_tuser_d;
  logic [IDX_W-1:0]    m_idx_q, m_idx_d;
  logic                m_sop_q, m_sop_d;
  logic                m_eop_q, m_eop_d;
  logic [CNT_W-1:0]    pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0]    short_q, short_d;
  logic [CNT_W-1:0]    long_q, long_d;
  logic                err_pulse_q, err_pulse_d;
  logic                accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // HUNT always drains the input, so ready never waits on the output stage there
  assign s_tready = (state_q == HUNT) || !m_tvalid_q || m_tready;
  assign accept   = s_tvalid && s_tready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    m_tvalid_d  = m_tvalid_q;
    m_tdata_d   = m_tdata_q;
    m_tuser_d   = m_tuser_q;
    m_idx_d     = m_idx_q;
    m_sop_d     = m_sop_q;
    m_eop_d     = m_eop_q;
    pkt_count_d = pkt_count_q;
    short_d     = short_q;
    long_d      = long_q;
    err_pulse_d = 1'b0;

    if (m_tready) begin
      m_tvalid_d = 1'b0;
    end

    if (accept) begin
      if (state_q == ALIGNED) begin
        m_tvalid_d = 1'b1;
        m_tdata_d  = s_tdata;
        m_tuser_d  = s_tuser;
        m_idx_d    = idx_q;
        m_sop_d    = (idx_q == '0);
        m_eop_d    = s_tlast;
        if (s_tlast) begin
          idx_d = '0;
          if (idx_q == LAST_IDX) begin
            pkt_count_d = sat_inc(pkt_count_q);
          end else begin
            short_d     = sat_inc(short_q);
            err_pulse_d = 1'b1;
          end
        end else if (idx_q == LAST_IDX) begin
          // Overlong packet: forward the full-length prefix, then hunt for its tlast
          long_d      = sat_inc(long_q);
          err_pulse_d = 1'b1;
          state_d     = HUNT;
          idx_d       = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else if (s_tlast) begin
        state_d = ALIGNED;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ALIGNED;
      idx_q       <= '0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tuser_q   <= '0;
      m_idx_q     <= '0;
      m_sop_q     <= 1'b0;
      m_eop_q     <= 1'b0;
      pkt_count_q <= '0;
      short_q     <= '0;
      long_q      <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
      m_tuser_q   <= m_tuser_d;
      m_idx_q     <= m_idx_d;
      m_sop_q     <= m_sop_d;
      m_eop_q     <= m_eop_d;
      pkt_count_q <= pkt_count_d;
      short_q     <= short_d;
      long_q      <= long_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign m_tvalid      = m_tvalid_q;
  assign m_tdata       = m_tdata_q;
  assign m_tuser       = m_tuser_q;
  assign m_idx         = m_idx_q;
  assign m_sop         = m_sop_q;
  assign m_eop         = m_eop_q;
  assign pkt_count     = pkt_count_q;
  assign short_err_cnt = short_q;
  assign long_err_cnt  = long_q;
  assign err_pulse     = err_pulse_q;
  assign aligned       = (state_q == ALIGNED);

endmodule

// File: tb/tb_axis_depacketizer.sv
// tb/tb_axis_depacketizer.sv - randomized self-checking bench for axis_depacketizer
// Expected beats come from a packet-level model: each packet is good, short or long by its length.
module tb_axis_depacketizer;

  localparam int DATA_W  = 32;
  localparam int USER_W  = 8;
  localparam int PKT_LEN = 256;
  localparam int CNT_W   = 16;
  localparam int IDX_W   = 8;
  localparam int BW      = DATA_W + USER_W + IDX_W + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [DATA_W-1:0] s_tdata;
  logic [USER_W-1:0] s_tuser;
  logic              s_tvalid, s_tready, s_tlast;
  logic [DATA_W-1:0] m_tdata;
  logic [USER_W-1:0] m_tuser;
  logic              m_tvalid, m_tready, m_sop, m_eop;
  logic [IDX_W-1:0]  m_idx;
  logic [CNT_W-1:0]  pkt_count, short_err_cnt, long_err_cnt;
  logic              err_pulse, aligned;

  axis_depacketizer #(.DATA_W(DATA_W), .USER_W(USER_W), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_sop(m_sop), .m_eop(m_eop), .m_idx(m_idx),
    .pkt_count(pkt_count), .short_err_cnt(short_err_cnt), .long_err_cnt(long_err_cnt),
    .err_pulse(err_pulse), .aligned(aligned)
  );

  // Small instance for counter saturation
  logic [DATA_W-1:0] sat_s_tdata;
  logic [USER_W-1:0] sat_s_tuser;
  logic              sat_s_tvalid, sat_s_tready, sat_s_tlast;
  logic [DATA_W-1:0] sat_m_tdata;
  logic [USER_W-1:0] sat_m_tuser;
  logic              sat_m_tvalid, sat_m_tready, sat_m_sop, sat_m_eop;
  logic [1:0]        sat_m_idx;
  logic [3:0]        sat_pkt_count, sat_short_cnt, sat_long_cnt;
  logic              sat_err_pulse, sat_aligned;

  axis_depacketizer #(.DATA_W(DATA_W), .USER_W(USER_W), .PKT_LEN(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .s_tdata(sat_s_tdata), .s_tuser(sat_s_tuser), .s_tvalid(sat_s_tvalid), .s_tready(sat_s_tready),
    .s_tlast(sat_s_tlast),
    .m_tdata(sat_m_tdata), .m_tuser(sat_m_tuser), .m_tvalid(sat_m_tvalid), .m_tready(sat_m_tready),
    .m_sop(sat_m_sop), .m_eop(sat_m_eop), .m_idx(sat_m_idx),
    .pkt_count(sat_pkt_count), .short_err_cnt(sat_short_cnt), .long_err_cnt(sat_long_cnt),
    .err_pulse(sat_err_pulse), .aligned(sat_aligned)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [USER_W-1:0] user;
    logic              last;
    logic              al;
  } in_beat_t;

  int tests = 0;
  int fails = 0;

  in_beat_t       in_q[$];
  logic [BW-1:0]  exp_q[$];
  logic [BW-1:0]  obs_q[$];
  logic           al_q[$];
  int             exp_pkt, exp_short, exp_long;
  int             stall_viol, err_seen;
  bit             timeout;

  task automatic mdl_clear();
    in_q.delete();
    exp_q.delete();
    exp_pkt = 0;
    exp_short = 0;
    exp_long = 0;
  endtask

  // Packets always start aligned: every packet, good or bad, leaves the receiver aligned at idx 0.
  task automatic add_packet(input int len, input int base);
    in_beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = DATA_W'(base + k);
      b.user = USER_W'($urandom);
      b.last = (k == len - 1);
      b.al   = (len > PKT_LEN) ? !(k >= PKT_LEN - 1 && k < len - 1) : 1'b1;
      if (k < PKT_LEN) exp_q.push_back({b.data, b.user, IDX_W'(k), (k == 0), b.last});
      in_q.push_back(b);
    end
    if (len == PKT_LEN) exp_pkt++;
    else if (len < PKT_LEN) exp_short++;
    else exp_long++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tuser = '0;
    m_tready = 1'b1;
    sat_s_tvalid = 1'b0; sat_s_tlast = 1'b0; sat_s_tdata = '0; sat_s_tuser = '0;
    sat_m_tready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives in_q and records accepted-beat alignment, output handshakes, stalls and error pulses.
  task automatic run_stream(input int vpct, input int rpct);
    bit drv_done;
    drv_done = 1'b0;
    obs_q.delete(); al_q.delete();
    stall_viol = 0; err_seen = 0; timeout = 1'b0;
    fork
      begin
        bit acc;
        foreach (in_q[i]) begin
          while ($urandom_range(99) >= vpct) begin
            s_tvalid = 1'b0;
            @(posedge clk); #1;
          end
          s_tvalid = 1'b1; s_tdata = in_q[i].data; s_tuser = in_q[i].user; s_tlast = in_q[i].last;
          do begin
            @(negedge clk); acc = s_tready;
            @(posedge clk); #1;
          end while (!acc && !timeout);
          if (timeout) break;
          al_q.push_back(aligned);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        drv_done = 1'b1;
      end
      begin
        logic [BW:0] prev, cur;
        bit stalled;
        int cyc, idle;
        stalled = 1'b0; cyc = 0; idle = 0; prev = '0;
        while (idle < 3 && !timeout) begin
          @(posedge clk); #1;
          m_tready = ($urandom_range(99) < rpct);
          @(negedge clk);
          cur = {m_tvalid, m_tdata, m_tuser, m_idx, m_sop, m_eop};
          if (stalled && cur !== prev) stall_viol++;
          if (err_pulse) err_seen++;
          if (m_tvalid && m_tready) obs_q.push_back(cur[BW-1:0]);
          stalled = m_tvalid && !m_tready;
          prev = cur;
          idle = (drv_done && !m_tvalid) ? idle + 1 : 0;
          cyc++;
          if (cyc > 40000) timeout = 1'b1;
        end
      end
    join
    m_tready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid got %b want 0", m_tvalid); end
    tests++; if (m_tdata !== '0) begin fails++; $display("FAIL rst_tdata got %h want 0", m_tdata); end
    tests++; if (m_tuser !== '0) begin fails++; $display("FAIL rst_tuser got %h want 0", m_tuser); end
    tests++; if (m_idx !== '0) begin fails++; $display("FAIL rst_idx got %0d want 0", m_idx); end
    tests++; if ({m_sop, m_eop} !== 2'b00) begin fails++; $display("FAIL rst_sop_eop got %b want 00", {m_sop, m_eop}); end
    tests++; if ({pkt_count, short_err_cnt, long_err_cnt} !== '0) begin
      fails++; $display("FAIL rst_counters got %0d/%0d/%0d want 0/0/0", pkt_count, short_err_cnt, long_err_cnt);
    end
    tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL rst_err_pulse got %b want 0", err_pulse); end
    tests++; if (aligned !== 1'b1) begin fails++; $display("FAIL rst_aligned got %b want 1", aligned); end
    tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL rst_s_tready got %b want 1", s_tready); end
    @(posedge clk); #1;
  endtask

  task automatic test_good_packets(input int vpct, input int rpct, input string tag);
    int bad, first;
    do_reset();
    mdl_clear();
    for (int p = 0; p < 3; p++) add_packet(PKT_LEN, p * PKT_LEN);
    run_stream(vpct, rpct);
    tests++; if (timeout) begin fails++; $display("FAIL %s_timeout got timeout want completion", tag); end
    bad = 0; first = -1;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    tests++;
    if (bad != 0 || obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s_beats got %0d beats (%0d wrong, first %0d) want %0d", tag, obs_q.size(), bad, first, exp_q.size());
    end
    tests++; if (pkt_count !== CNT_W'(exp_pkt)) begin fails++; $display("FAIL %s_pkt_count got %0d want %0d", tag, pkt_count, exp_pkt); end
    tests++; if (short_err_cnt !== '0 || long_err_cnt !== '0) begin
      fails++; $display("FAIL %s_err_cnts got %0d/%0d want 0/0", tag, short_err_cnt, long_err_cnt);
    end
    tests++; if (err_seen != 0) begin fails++; $display("FAIL %s_err_pulse got %0d pulses want 0", tag, err_seen); end
    tests++; if (stall_viol != 0) begin fails++; $display("FAIL %s_stall_stable got %0d changes want 0", tag, stall_viol); end
  endtask

  task automatic test_short_packet();
    int bad, first;
    do_reset();
    mdl_clear();
    add_packet(100, 0);
    add_packet(PKT_LEN, 100);
    run_stream(90, 80);
    tests++; if (timeout) begin fails++; $display("FAIL short_timeout got timeout want completion"); end
    bad = 0; first = -1;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    tests++;
    if (bad != 0 || obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL short_beats got %0d beats (%0d wrong, first %0d) want %0d", obs_q.size(), bad, first, exp_q.size());
    end
    tests++; if (short_err_cnt !== CNT_W'(exp_short)) begin fails++; $display("FAIL short_cnt got %0d want %0d", short_err_cnt, exp_short); end
    tests++; if (long_err_cnt !== CNT_W'(exp_long)) begin fails++; $display("FAIL short_long_cnt got %0d want %0d", long_err_cnt, exp_long); end
    tests++; if (pkt_count !== CNT_W'(exp_pkt)) begin fails++; $display("FAIL short_pkt_count got %0d want %0d", pkt_count, exp_pkt); end
    tests++; if (err_seen != exp_short + exp_long) begin fails++; $display("FAIL short_err_pulse got %0d want %0d", err_seen, exp_short + exp_long); end
    tests++; if (stall_viol != 0) begin fails++; $display("FAIL short_stall_stable got %0d want 0", stall_viol); end
  endtask

  task automatic test_long_packet();
    int bad, first;
    do_reset();
    mdl_clear();
    add_packet(300, 0);
    add_packet(PKT_LEN, 300);
    run_stream(85, 75);
    tests++; if (timeout) begin fails++; $display("FAIL long_timeout got timeout want completion"); end
    bad = 0; first = -1;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    tests++;
    if (bad != 0 || obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL long_beats got %0d beats (%0d wrong, first %0d) want %0d", obs_q.size(), bad, first, exp_q.size());
    end
    bad = 0; first = -1;
    foreach (in_q[i]) if (i >= al_q.size() || al_q[i] !== in_q[i].al) begin bad++; if (first < 0) first = i; end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL long_aligned got %0d wrong samples (first at beat %0d) want 0", bad, first);
    end
    tests++; if (long_err_cnt !== CNT_W'(exp_long)) begin fails++; $display("FAIL long_cnt got %0d want %0d", long_err_cnt, exp_long); end
    tests++; if (short_err_cnt !== CNT_W'(exp_short)) begin fails++; $display("FAIL long_short_cnt got %0d want %0d", short_err_cnt, exp_short); end
    tests++; if (pkt_count !== CNT_W'(exp_pkt)) begin fails++; $display("FAIL long_pkt_count got %0d want %0d", pkt_count, exp_pkt); end
    tests++; if (err_seen != exp_short + exp_long) begin fails++; $display("FAIL long_err_pulse got %0d want %0d", err_seen, exp_short + exp_long); end
    tests++; if (aligned !== 1'b1) begin fails++; $display("FAIL long_realigned got %b want 1", aligned); end
  endtask

  task automatic test_mid_reset();
    int bad, first;
    do_reset();
    m_tready = 1'b1;
    for (int k = 0; k < 128; k++) begin
      s_tvalid = 1'b1; s_tdata = DATA_W'(5000 + k); s_tuser = USER_W'($urandom); s_tlast = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b1; s_tdata = DATA_W'(5128);
    @(posedge clk); #1;
    rst = 1'b0; s_tvalid = 1'b0;
    @(negedge clk);
    tests++;
    if ({m_tvalid, m_sop, m_eop, err_pulse} !== 4'b0000 || m_tdata !== '0 || m_tuser !== '0 || m_idx !== '0) begin
      fails++;
      $display("FAIL midrst_outputs got v=%b d=%h u=%h i=%0d s=%b e=%b p=%b want all zero",
               m_tvalid, m_tdata, m_tuser, m_idx, m_sop, m_eop, err_pulse);
    end
    tests++;
    if ({pkt_count, short_err_cnt, long_err_cnt} !== '0 || aligned !== 1'b1) begin
      fails++;
      $display("FAIL midrst_state got cnt=%0d/%0d/%0d al=%b want 0/0/0 al=1", pkt_count, short_err_cnt, long_err_cnt, aligned);
    end
    @(posedge clk); #1;
    mdl_clear();
    add_packet(PKT_LEN, 9000);
    run_stream(100, 100);
    bad = 0; first = -1;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    tests++;
    if (timeout || bad != 0 || obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL midrst_beats got %0d beats (%0d wrong, first %0d, timeout %0d) want %0d",
               obs_q.size(), bad, first, timeout, exp_q.size());
    end
    tests++; if (pkt_count !== CNT_W'(1)) begin fails++; $display("FAIL midrst_pkt_count got %0d want 1", pkt_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int p = 1; p <= 20; p++) begin
      for (int k = 0; k < 4; k++) begin
        sat_s_tvalid = 1'b1; sat_s_tdata = DATA_W'(p * 4 + k); sat_s_tuser = '0; sat_s_tlast = (k == 3);
        @(posedge clk); #1;
      end
      tests++;
      if (sat_pkt_count !== 4'((p > 15) ? 15 : p)) begin
        fails++; $display("FAIL sat_pkt_count[%0d] got %0d want %0d", p, sat_pkt_count, (p > 15) ? 15 : p);
      end
    end
    sat_s_tvalid = 1'b0; sat_s_tlast = 1'b0;
    tests++;
    if (sat_short_cnt !== 4'd0 || sat_long_cnt !== 4'd0) begin
      fails++; $display("FAIL sat_err_cnts got %0d/%0d want 0/0", sat_short_cnt, sat_long_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_good_packets(100, 100, "inorder");
    test_good_packets(70, 50, "random");
    test_short_packet();
    test_long_packet();
    test_mid_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
